dyn_branch_predictor: RTL and testbench
=======================================

Name: dyn_branch_predictor

Overview:
- Parametrised dynamic branch predictor. Replaces the static "flush when branch && Zero" scheme.
- The IF stage looks up a direct-mapped BHT/BTB (saturating counters, tags, targets) to produce a speculative next PC.
- The EX stage resolves the branch, trains the table and raises flush/redirect on a mispredict.
- Also keeps branch and mispredict performance counters for the debug bus.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 64, table depth; power of 2, 4..1024; IDX_W = log2(ENTRIES).
- TAG_W, 8, tag bits stored per entry.
- CTR_W, 2, saturating counter width; 1..4.
- CNT_W, 32, width of each performance counter.

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- pc_if, in, XLEN, PC of the instruction in fetch.
- pred_taken, out, 1, predict taken (combinational from pc_if).
- pred_target, out, XLEN, predicted target; equals pc_if+4 when pred_taken=0.
- ex_valid, in, 1, EX holds a live (non-bubble, non-flushed) instruction.
- ex_is_branch, in, 1, conditional branch in EX.
- ex_is_jump, in, 1, JAL/JALR in EX.
- ex_pc, in, XLEN, PC of the EX instruction.
- ex_taken, in, 1, actual outcome (jumps drive 1).
- ex_target, in, XLEN, actual taken target.
- ex_pred_taken, in, 1, prediction carried down the pipeline with the instruction.
- ex_pred_target, in, XLEN, predicted target carried down the pipeline.
- flush, out, 1, squash IF/ID and ID/EX.
- redirect_pc, out, XLEN, PC to fetch when flush=1.
- branch_cnt, out, CNT_W, resolved branches plus jumps.
- mispred_cnt, out, CNT_W, mispredicts.

Behaviour:
- Index = pc[IDX_W+1:2]. Tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- Each entry holds: valid, tag, ctr[CTR_W], target[XLEN].
- Reset (async assert, sync deassert by the top level):
  - all valid = 0;
  - all ctr = weakly-not-taken, i.e. 2^(CTR_W-1)-1 (01 for CTR_W=2);
  - branch_cnt = mispred_cnt = 0;
  - with all entries invalid, pred_taken = 0 and pred_target = pc_if+4.
- Lookup (0-cycle, combinational): hit = valid & tag match; pred_taken = hit & ctr MSB; pred_target = pred_taken ? target : pc_if+4.
- res = ex_valid & (ex_is_branch | ex_is_jump). When res=0: flush=0, redirect_pc=ex_pc+4, no state change.
- mispredict = res & ((ex_taken != ex_pred_taken) | (ex_taken & ex_pred_taken & ex_target != ex_pred_target)).
- flush = mispredict (combinational, same cycle as EX).
- redirect_pc = ex_taken ? ex_target : ex_pc+4.
- Training (on the clk edge where res=1, indexed by ex_pc):
  - Hit, branch: ctr saturating +1 if taken, else -1. Holds at 0 and at 2^CTR_W-1 (no wrap).
  - Hit, taken: target <= ex_target.
  - Miss, taken: allocate. valid=1, tag, target=ex_target, ctr = weakly-taken 2^(CTR_W-1); any previous occupant is overwritten.
  - Miss, not taken: no allocation, no change.
  - Jump (hit or miss): ctr = 2^CTR_W-1 and target = ex_target.
- Same-cycle read/write to the same index: lookup returns the pre-update contents. No bypass.
- Counters:
  - branch_cnt += 1 per res;
  - mispred_cnt += 1 per mispredict;
  - both saturate at all-ones (no wrap).
- Both ex_is_branch and ex_is_jump set: treated as a jump.
- Reset asserted mid-operation: table and counters clear immediately; flush follows its inputs.

Test Plan:
- Reset, then pc_if=0x100 -> pred_taken=0, pred_target=0x104, both counters 0.
- Branch at 0x100 resolves taken to 0x80 with ex_pred_taken=0:
  - -> flush=1, redirect_pc=0x80, branch_cnt=1, mispred_cnt=1;
  - next cycle pc_if=0x100 -> pred_taken=1, pred_target=0x80.
- Same branch resolved not-taken twice with matching predictions (CTR_W=2):
  - ctr goes 10 -> 01 -> 00; pred_taken=0 from the first update on;
  - flush only when the prediction was wrong;
  - four more not-takens leave ctr at 00 (saturation).
- Alias check (ENTRIES=64): ex_pc 0x100 and 0x200 share an index with different tags.
  - 0x200 taken to 0x40 overwrites the entry;
  - pc_if=0x100 then misses -> pred_taken=0.
- Taken/taken target change: JALR at 0x300 resolves to 0x500, ex_pred_target=0x400, ex_pred_taken=1.
  - -> flush=1, redirect_pc=0x500, entry target updated to 0x500.
- Saturation and reset:
  - force mispred_cnt to all-ones via 2^CNT_W events (use CNT_W=4) -> counter holds at 0xF;
  - drop rst_n mid-stream -> all outputs and counters return to reset values asynchronously.

Source files
------------

// File: rtl/dyn_branch_predictor.sv
// Direct-mapped BHT/BTB branch predictor with EX-stage training,
// mispredict flush/redirect and saturating branch/mispredict counters.
module dyn_branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  pc_if,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jump,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             ex_taken,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  output logic             flush,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TOP   = IDX_W + TAG_W + 2;

  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [CTR_W-1:0] ctr_q   [ENTRIES];
  logic [XLEN-1:0]  tgt_q   [ENTRIES];

  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] br_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q;
  logic [CNT_W-1:0] mis_cnt_d;

  logic [IDX_W-1:0] ridx;
  logic [TAG_W-1:0] rtag;
  logic             rhit;
  logic [XLEN-1:0]  pc_if_p4;

  logic [IDX_W-1:0] widx;
  logic [TAG_W-1:0] wtag;
  logic             whit;
  logic [CTR_W-1:0] wctr;
  logic [XLEN-1:0]  ex_pc_p4;

  logic             res;
  logic             is_jmp;
  logic             mispred;

  logic             we_meta;
  logic             we_tgt;
  logic [CTR_W-1:0] ctr_d;
  logic [TAG_W-1:0] tag_d;
  logic [XLEN-1:0]  tgt_d;

  logic             unused_pc;

  assign unused_pc = ^{pc_if[XLEN-1:TOP], pc_if[1:0],
                       ex_pc[XLEN-1:TOP], ex_pc[1:0]};

  // Fetch-side lookup
  assign ridx     = pc_if[IDX_W+1:2];
  assign rtag     = pc_if[TOP-1:IDX_W+2];
  assign rhit     = valid_q[ridx] && (tag_q[ridx] == rtag);
  assign pc_if_p4 = pc_if + XLEN'(4);

  assign pred_taken  = rhit & ctr_q[ridx][CTR_W-1];
  assign pred_target = pred_taken ? tgt_q[ridx] : pc_if_p4;

  // Execute-side resolution
  assign widx     = ex_pc[IDX_W+1:2];
  assign wtag     = ex_pc[TOP-1:IDX_W+2];
  assign whit     = valid_q[widx] && (tag_q[widx] == wtag);
  assign wctr     = ctr_q[widx];
  assign ex_pc_p4 = ex_pc + XLEN'(4);

  assign res     = ex_valid & (ex_is_branch | ex_is_jump);
  assign is_jmp  = ex_is_jump;
  assign mispred = res & ((ex_taken != ex_pred_taken) |
                   (ex_taken & ex_pred_taken &
                    (ex_target != ex_pred_target)));

  assign flush       = mispred;
  assign redirect_pc = (res & ex_taken) ? ex_target : ex_pc_p4;

  always_comb begin
    we_meta = 1'b0;
    we_tgt  = 1'b0;
    ctr_d   = wctr;
    tag_d   = wtag;
    tgt_d   = ex_target;
    if (res) begin
      unique case (1'b1)
        is_jmp: begin
          we_meta = 1'b1;
          we_tgt  = 1'b1;
          ctr_d   = CTR_MAX;
        end
        !is_jmp && whit: begin
          we_meta = 1'b1;
          we_tgt  = ex_taken;
          if (ex_taken) begin
            ctr_d = (wctr == CTR_MAX) ? wctr : wctr + CTR_W'(1);
          end else begin
            ctr_d = (wctr == '0) ? wctr : wctr - CTR_W'(1);
          end
        end
        !is_jmp && !whit && ex_taken: begin
          we_meta = 1'b1;
          we_tgt  = 1'b1;
          ctr_d   = CTR_WT;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (res && br_cnt_q != CNT_MAX) begin
      br_cnt_d = br_cnt_q + CNT_W'(1);
    end
    if (mispred && mis_cnt_q != CNT_MAX) begin
      mis_cnt_d = mis_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        ctr_q[i]   <= CTR_WNT;
      end
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (we_meta) begin
        valid_q[widx] <= 1'b1;
        tag_q[widx]   <= tag_d;
        ctr_q[widx]   <= ctr_d;
      end
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  // Targets are only read behind a valid bit, so they need no reset
  always_ff @(posedge clk) begin
    if (we_tgt) begin
      tgt_q[widx] <= tgt_d;
    end
  end

  assign branch_cnt  = br_cnt_q;
  assign mispred_cnt = mis_cnt_q;

endmodule

// File: tb/tb_dyn_branch_predictor.sv
// Randomised and directed checks of dyn_branch_predictor against a
// table-level reference model kept in the bench.
module tb_dyn_branch_predictor;

  localparam int ENT  = 64;
  localparam int CTRW = 2;
  localparam int CMAX = (1 << CTRW) - 1;
  localparam int CWT  = 1 << (CTRW - 1);
  localparam int CWNT = CWT - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_if;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_is_jump;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;

  logic        pred_taken;
  logic [31:0] pred_target;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  logic        pred_taken4;
  logic [31:0] pred_target4;
  logic        flush4;
  logic [31:0] redirect_pc4;
  logic [3:0]  branch_cnt4;
  logic [3:0]  mispred_cnt4;

  int checks = 0;
  int errors = 0;

  bit          mv   [ENT];
  int          mtag [ENT];
  int          mctr [ENT];
  logic [31:0] mtgt [ENT];
  longint      mbr, mmis, mbr4, mmis4;

  always #5 clk = ~clk;

  dyn_branch_predictor u_dut (
    .clk(clk), .rst_n(rst_n), .pc_if(pc_if),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_is_jump(ex_is_jump), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .flush(flush),
    .redirect_pc(redirect_pc), .branch_cnt(branch_cnt),
    .mispred_cnt(mispred_cnt)
  );

  dyn_branch_predictor #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .pc_if(pc_if),
    .pred_taken(pred_taken4), .pred_target(pred_target4),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_is_jump(ex_is_jump), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .flush(flush4),
    .redirect_pc(redirect_pc4), .branch_cnt(branch_cnt4),
    .mispred_cnt(mispred_cnt4)
  );

  function automatic int m_idx(logic [31:0] pc);
    return int'((pc / 4) % ENT);
  endfunction

  function automatic int m_tag(logic [31:0] pc);
    return int'((pc / (4 * ENT)) % 256);
  endfunction

  function automatic bit m_ptaken(logic [31:0] pc);
    int i = m_idx(pc);
    return mv[i] && mtag[i] == m_tag(pc) && mctr[i] >= CWT;
  endfunction

  function automatic logic [31:0] m_ptgt(logic [31:0] pc);
    return m_ptaken(pc) ? mtgt[m_idx(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_res();
    return ex_valid && (ex_is_branch || ex_is_jump);
  endfunction

  function automatic bit m_mis();
    return m_res() && ((ex_taken != ex_pred_taken) ||
      (ex_taken && ex_pred_taken && ex_target != ex_pred_target));
  endfunction

  function automatic logic [31:0] m_redir();
    return (m_res() && ex_taken) ? ex_target : ex_pc + 32'd4;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ENT; i++) begin
      mv[i]   = 0;
      mtag[i] = 0;
      mctr[i] = CWNT;
      mtgt[i] = '0;
    end
    mbr = 0; mmis = 0; mbr4 = 0; mmis4 = 0;
  endtask

  task automatic m_train();
    int i;
    bit hit;
    bit mis;
    if (!m_res()) return;
    mis = m_mis();
    i   = m_idx(ex_pc);
    hit = mv[i] && mtag[i] == m_tag(ex_pc);
    if (ex_is_jump) begin
      mv[i] = 1; mtag[i] = m_tag(ex_pc);
      mctr[i] = CMAX; mtgt[i] = ex_target;
    end else if (hit) begin
      if (ex_taken) begin
        if (mctr[i] < CMAX) mctr[i]++;
        mtgt[i] = ex_target;
      end else if (mctr[i] > 0) begin
        mctr[i]--;
      end
    end else if (ex_taken) begin
      mv[i] = 1; mtag[i] = m_tag(ex_pc);
      mctr[i] = CWT; mtgt[i] = ex_target;
    end
    if (mbr < 64'hFFFF_FFFF) mbr++;
    if (mbr4 < 15) mbr4++;
    if (mis && mmis < 64'hFFFF_FFFF) mmis++;
    if (mis && mmis4 < 15) mmis4++;
  endtask

  task automatic idle();
    ex_valid = 0; ex_is_branch = 0; ex_is_jump = 0;
    ex_pc = 32'h0; ex_taken = 0; ex_target = 32'h0;
    ex_pred_taken = 0; ex_pred_target = 32'h0;
  endtask

  task automatic drive(bit br, bit jp, logic [31:0] pc, bit tk,
                       logic [31:0] tg, bit ptk, logic [31:0] ptg);
    ex_valid = 1; ex_is_branch = br; ex_is_jump = jp;
    ex_pc = pc; ex_taken = tk; ex_target = tg;
    ex_pred_taken = ptk; ex_pred_target = ptg;
  endtask

  task automatic cyc();
    m_train();
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick_pc();
    case ($urandom_range(0, 7))
      0: return 32'h100;
      1: return 32'h200;
      2: return 32'h104;
      3: return 32'h300;
      4: return 32'h1100;
      5: return 32'h3C0;
      6: return 32'h2200;
      default: return $urandom & 32'h0000_FFFC;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 0; idle(); pc_if = 32'h100;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++; $display("FAIL reset_pt got %0b exp 0", pred_taken);
    end
    checks++;
    if (pred_target !== 32'h104) begin
      errors++; $display("FAIL reset_ptgt got %h exp 104", pred_target);
    end
    checks++;
    if (branch_cnt !== 0 || mispred_cnt !== 0 || mispred_cnt4 !== 0) begin
      errors++;
      $display("FAIL reset_cnt got %0d/%0d/%0d exp 0",
               branch_cnt, mispred_cnt, mispred_cnt4);
    end
    checks++;
    if (flush !== 1'b0 || redirect_pc !== 32'h4) begin
      errors++;
      $display("FAIL reset_flush got %0b %h exp 0 4", flush, redirect_pc);
    end
    m_reset();
    @(negedge clk); rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_alloc();
    drive(1, 0, 32'h100, 1, 32'h80, 0, 32'h104);
    pc_if = 32'h100;
    #1;
    checks++;
    if (flush !== 1'b1 || redirect_pc !== 32'h80) begin
      errors++;
      $display("FAIL alloc_flush got %0b %h exp 1 80", flush, redirect_pc);
    end
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++; $display("FAIL alloc_nobypass got %0b exp 0", pred_taken);
    end
    cyc();
    checks++;
    if (branch_cnt !== 32'd1 || mispred_cnt !== 32'd1) begin
      errors++;
      $display("FAIL alloc_cnt got %0d %0d exp 1 1", branch_cnt, mispred_cnt);
    end
    idle(); pc_if = 32'h100;
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
      errors++;
      $display("FAIL alloc_pred got %0b %h exp 1 80", pred_taken, pred_target);
    end
  endtask

  task automatic test_ctr_decay();
    for (int k = 0; k < 6; k++) begin
      drive(1, 0, 32'h100, 0, 32'h80, m_ptaken(32'h100), m_ptgt(32'h100));
      #1;
      checks++;
      if (flush !== (k == 0)) begin
        errors++;
        $display("FAIL decay_flush%0d got %0b exp %0b", k, flush, k == 0);
      end
      cyc();
      idle(); pc_if = 32'h100;
      #1;
      checks++;
      if (pred_taken !== 1'b0) begin
        errors++; $display("FAIL decay_pt%0d got %0b exp 0", k, pred_taken);
      end
    end
    drive(1, 0, 32'h100, 1, 32'h80, 0, 32'h104);
    cyc();
    idle(); pc_if = 32'h100;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++; $display("FAIL decay_floor got %0b exp 0", pred_taken);
    end
  endtask

  task automatic test_alias();
    drive(1, 0, 32'h200, 1, 32'h40, 0, 32'h204);
    #1;
    checks++;
    if (flush !== 1'b1) begin
      errors++; $display("FAIL alias_flush got %0b exp 1", flush);
    end
    cyc();
    idle(); pc_if = 32'h100;
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      errors++;
      $display("FAIL alias_miss got %0b %h exp 0 104", pred_taken, pred_target);
    end
    pc_if = 32'h200;
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h40) begin
      errors++;
      $display("FAIL alias_hit got %0b %h exp 1 40", pred_taken, pred_target);
    end
  endtask

  task automatic test_jump_target();
    drive(0, 1, 32'h300, 1, 32'h400, 0, 32'h304);
    cyc();
    idle(); pc_if = 32'h300;
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h400) begin
      errors++;
      $display("FAIL jmp_alloc got %0b %h exp 1 400", pred_taken, pred_target);
    end
    drive(0, 1, 32'h300, 1, 32'h500, 1, 32'h400);
    #1;
    checks++;
    if (flush !== 1'b1 || redirect_pc !== 32'h500) begin
      errors++;
      $display("FAIL jmp_tgt got %0b %h exp 1 500", flush, redirect_pc);
    end
    cyc();
    idle(); pc_if = 32'h300;
    #1;
    checks++;
    if (pred_target !== 32'h500) begin
      errors++; $display("FAIL jmp_upd got %h exp 500", pred_target);
    end
    drive(0, 1, 32'h300, 1, 32'h500, 1, 32'h500);
    #1;
    checks++;
    if (flush !== 1'b0) begin
      errors++; $display("FAIL jmp_match got %0b exp 0", flush);
    end
    cyc();
  endtask

  task automatic test_both_flags();
    drive(1, 1, 32'h3C0, 1, 32'h700, 0, 32'h3C4);
    cyc();
    drive(1, 0, 32'h3C0, 0, 32'h700, 1, 32'h700);
    #1;
    checks++;
    if (flush !== 1'b1 || redirect_pc !== 32'h3C4) begin
      errors++;
      $display("FAIL both_flush got %0b %h exp 1 3c4", flush, redirect_pc);
    end
    cyc();
    idle(); pc_if = 32'h3C0;
    #1;
    checks++;
    if (pred_taken !== 1'b1) begin
      errors++; $display("FAIL both_strong got %0b exp 1", pred_taken);
    end
  endtask

  task automatic test_no_res();
    longint br0 = mbr;
    drive(1, 0, 32'h500, 1, 32'h900, 0, 32'h504);
    ex_valid = 0;
    #1;
    checks++;
    if (flush !== 1'b0 || redirect_pc !== 32'h504) begin
      errors++;
      $display("FAIL nores_out got %0b %h exp 0 504", flush, redirect_pc);
    end
    cyc();
    drive(0, 0, 32'h500, 1, 32'h900, 0, 32'h504);
    cyc();
    checks++;
    if (longint'(branch_cnt) !== br0) begin
      errors++; $display("FAIL nores_cnt got %0d exp %0d", branch_cnt, br0);
    end
    idle(); pc_if = 32'h500;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++; $display("FAIL nores_tbl got %0b exp 0", pred_taken);
    end
  endtask

  task automatic test_random();
    logic [31:0] pool [4] = '{32'h40, 32'h80, 32'h500, 32'h1000};
    for (int n = 0; n < 600; n++) begin
      logic [31:0] pc;
      bit jp;
      pc = pick_pc();
      jp = ($urandom_range(0, 4) == 0);
      drive($urandom_range(0, 3) != 0, jp, pc,
            jp ? 1'b1 : 1'($urandom_range(0, 1)),
            pool[$urandom_range(0, 3)], 0, 32'h0);
      ex_valid = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) < 7) begin
        ex_pred_taken  = m_ptaken(pc);
        ex_pred_target = m_ptgt(pc);
      end else begin
        ex_pred_taken  = 1'($urandom_range(0, 1));
        ex_pred_target = pool[$urandom_range(0, 3)];
      end
      pc_if = pick_pc();
      #1;
      checks++;
      if (pred_taken !== m_ptaken(pc_if) ||
          pred_target !== m_ptgt(pc_if)) begin
        errors++;
        $display("FAIL rnd_pred n=%0d pc=%h got %0b %h exp %0b %h", n,
                 pc_if, pred_taken, pred_target,
                 m_ptaken(pc_if), m_ptgt(pc_if));
      end
      checks++;
      if (flush !== m_mis() || redirect_pc !== m_redir()) begin
        errors++;
        $display("FAIL rnd_flush n=%0d got %0b %h exp %0b %h", n,
                 flush, redirect_pc, m_mis(), m_redir());
      end
      cyc();
      checks++;
      if (longint'(branch_cnt) !== mbr || longint'(mispred_cnt) !== mmis ||
          longint'(branch_cnt4) !== mbr4 ||
          longint'(mispred_cnt4) !== mmis4) begin
        errors++;
        $display("FAIL rnd_cnt n=%0d got %0d %0d %0d %0d exp %0d %0d %0d %0d",
                 n, branch_cnt, mispred_cnt, branch_cnt4, mispred_cnt4,
                 mbr, mmis, mbr4, mmis4);
      end
    end
    idle();
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 20; k++) begin
      drive(1, 0, 32'h104, 1, 32'h80, 0, 32'h108);
      cyc();
    end
    idle();
    checks++;
    if (mispred_cnt4 !== 4'hF || branch_cnt4 !== 4'hF) begin
      errors++;
      $display("FAIL sat_cnt4 got %h %h exp f f", mispred_cnt4, branch_cnt4);
    end
    checks++;
    if (longint'(mispred_cnt) !== mmis) begin
      errors++; $display("FAIL sat_cnt32 got %0d exp %0d", mispred_cnt, mmis);
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 32'h100, 1, 32'h80, 0, 32'h104);
    pc_if = 32'h200;
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    m_reset();
    checks++;
    if (branch_cnt !== 0 || mispred_cnt !== 0 ||
        branch_cnt4 !== 0 || mispred_cnt4 !== 0) begin
      errors++;
      $display("FAIL rmid_cnt got %0d %0d %0d %0d exp 0",
               branch_cnt, mispred_cnt, branch_cnt4, mispred_cnt4);
    end
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h204) begin
      errors++;
      $display("FAIL rmid_pred got %0b %h exp 0 204", pred_taken, pred_target);
    end
    checks++;
    if (flush !== 1'b1 || redirect_pc !== 32'h80) begin
      errors++;
      $display("FAIL rmid_flush got %0b %h exp 1 80", flush, redirect_pc);
    end
    @(negedge clk);
    idle();
    rst_n = 1;
    @(negedge clk);
    pc_if = 32'h200;
    #1;
    checks++;
    if (pred_taken !== 1'b0 || branch_cnt !== 0) begin
      errors++;
      $display("FAIL rmid_after got %0b %0d exp 0 0", pred_taken, branch_cnt);
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_alloc();
    test_ctr_decay();
    test_alias();
    test_jump_target();
    test_both_flags();
    test_no_res();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
